// File: rtl/game_pkg.sv
// Shared types and constants for the two-tank game blocks.
package game_pkg;

    typedef enum logic [1:0] {
        AIM    = 2'd0,
        SHOT   = 2'd1,
        SWITCH = 2'd2
    } turn_state_t;

    localparam logic [7:0] KEY_FIRE  = 8'h2C;
    localparam logic [7:0] KEY_SKIP  = 8'h2B;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;

    localparam int FRAME_HZ = 60;

    // Width needed to hold the largest of three frame counts.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/frame_counter.sv
// Loadable frame counter, counting up or down, that saturates at its terminal
// count (LIMIT when counting up, zero when counting down) and flags it on tc.
module frame_counter #(
    parameter int               WIDTH       = 10,
    parameter bit               UP          = 1'b0,
    parameter logic [WIDTH-1:0] LIMIT       = '0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             Reset,
    input  logic             frame_clk,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    assign tc = UP ? (count == LIMIT) : (count == '0);

    // Load wins over counting; counting stops at the terminal count.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (en && !tc) begin
            count <= UP ? count + 1'b1 : count - 1'b1;
        end
    end

endmodule

// File: rtl/turn_sequencer.sv
// Turn arbiter for the two-tank game: AIM countdown, SHOT wait, SWITCH gap.
// Build with TURN_SKIP_EN defined to let tab end an armed turn early.
module turn_sequencer
    import game_pkg::*;
#(
    parameter int         TURN_FRAMES   = 600,
    parameter int         SHOT_TIMEOUT  = 240,
    parameter int         SWITCH_FRAMES = 30,
    parameter logic [7:0] FIRE_KEY      = KEY_FIRE
) (
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       bullet_active,
    output logic       player1flag,
    output logic       player2flag,
    output logic       fire_req,
    output logic       fire_owner,
    output logic [9:0] turn_timer,
    output logic       cur_player,
    output logic [7:0] turn_count
);

    localparam int               CNT_W      = cnt_width(TURN_FRAMES, SHOT_TIMEOUT, SWITCH_FRAMES);
    localparam logic [CNT_W-1:0] TURN_LOAD  = CNT_W'(TURN_FRAMES);
    localparam logic [CNT_W-1:0] SHOT_LAST  = CNT_W'(SHOT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SWITCH_LAST = CNT_W'(SWITCH_FRAMES - 1);

    turn_state_t state, state_n;
    logic        cur_player_n, armed, armed_n, seen_active, seen_n;
    logic        fire_req_n, fire_owner_n;
    logic [7:0]  turn_count_n;
    logic        fire_hit, skip_hit;
    logic        turn_en, turn_load;
    logic [CNT_W-1:0] turn_cnt, shot_cnt, switch_cnt;
    logic        turn_tc, shot_tc, switch_tc;

    frame_counter #(.WIDTH(CNT_W), .UP(1'b0), .LIMIT('0), .RESET_VALUE(TURN_LOAD)) u_turn (
        .Reset(Reset), .frame_clk(frame_clk), .load(turn_load), .load_value(TURN_LOAD),
        .en(turn_en), .count(turn_cnt), .tc(turn_tc)
    );

    // Shot and switch timers sit at zero until their phase starts.
    frame_counter #(.WIDTH(CNT_W), .UP(1'b1), .LIMIT(SHOT_LAST), .RESET_VALUE('0)) u_shot (
        .Reset(Reset), .frame_clk(frame_clk), .load(state != SHOT), .load_value('0),
        .en(state == SHOT), .count(shot_cnt), .tc(shot_tc)
    );

    frame_counter #(.WIDTH(CNT_W), .UP(1'b1), .LIMIT(SWITCH_LAST), .RESET_VALUE('0)) u_switch (
        .Reset(Reset), .frame_clk(frame_clk), .load(state != SWITCH), .load_value('0),
        .en(state == SWITCH), .count(switch_cnt), .tc(switch_tc)
    );

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state       <= AIM;
            cur_player  <= 1'b0;
            armed       <= 1'b0;
            seen_active <= 1'b0;
            fire_req    <= 1'b0;
            fire_owner  <= 1'b0;
            turn_count  <= 8'd0;
        end else begin
            state       <= state_n;
            cur_player  <= cur_player_n;
            armed       <= armed_n;
            seen_active <= seen_n;
            fire_req    <= fire_req_n;
            fire_owner  <= fire_owner_n;
            turn_count  <= turn_count_n;
        end
    end

    always_comb begin
        state_n      = state;
        cur_player_n = cur_player;
        armed_n      = armed;
        seen_n       = seen_active;
        fire_req_n   = 1'b0;
        fire_owner_n = fire_owner;
        turn_count_n = turn_count;
        fire_hit     = 1'b0;
        skip_hit     = 1'b0;
        turn_en      = 1'b0;
        turn_load    = 1'b0;
        case (state)
            AIM: begin
                // A held fire key must be released before it can fire.
                fire_hit = armed && (keycode == FIRE_KEY);
`ifdef TURN_SKIP_EN
                skip_hit = armed && (keycode == KEY_SKIP);
`else
                skip_hit = 1'b0;
`endif
                if (keycode != FIRE_KEY) armed_n = 1'b1;
                if (fire_hit) begin
                    fire_req_n   = 1'b1;
                    fire_owner_n = cur_player;
                    seen_n       = 1'b0;
                    state_n      = SHOT;
                end else if (skip_hit || turn_tc) begin
                    state_n = SWITCH;
                end else begin
                    turn_en = 1'b1;
                end
            end
            SHOT: begin
                if (bullet_active) seen_n = 1'b1;
                if ((seen_active && !bullet_active) || shot_tc) state_n = SWITCH;
            end
            SWITCH: begin
                if (switch_tc) begin
                    cur_player_n = ~cur_player;
                    turn_count_n = turn_count + 8'd1;
                    turn_load    = 1'b1;
                    armed_n      = 1'b0;
                    state_n      = AIM;
                end
            end
            default: begin
                state_n      = AIM;
                cur_player_n = 1'b0;
                armed_n      = 1'b0;
                seen_n       = 1'b0;
                fire_owner_n = 1'b0;
                turn_count_n = 8'd0;
                turn_load    = 1'b1;
            end
        endcase
    end

    assign player1flag = (state == AIM) && !cur_player;
    assign player2flag = (state == AIM) && cur_player;
    assign turn_timer  = 10'(turn_cnt);

endmodule
